// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
//   PS2_EXT_PREFIX / PS2_BREAK_PREFIX : scan-code prefixes folded into events
//   ps2_state_e                       : deframer FSM states
//   ps2_entry_t                       : one buffered key event {ext, brk, code}
package ps2_pkg;

   localparam logic [7:0]  PS2_EXT_PREFIX   = 8'hE0;
   localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
   localparam int unsigned PS2_FRAME_BITS   = 11;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } ps2_state_e;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

   // Frame is {stop, parity, data[7:0], start}; valid when start=0, stop=1, odd weight.
   function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
      return !f[0] && f[10] && (^f[9:1]);
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n  : clock, async active-low reset
//   push_i/din_i: write request and data; dropped (overflow_o pulse) when full
//                 unless a pop happens in the same cycle
//   pop_i       : consume head entry; ignored when empty
//   dout_o      : head entry (zero when empty), valid_o: non-empty
//   empty_o, full_o, level_o : occupancy status
//   overflow_o  : one-cycle pulse for each dropped push
module ps2_rx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push_i,
   input  logic [WIDTH-1:0]               din_i,
   input  logic                           pop_i,
   output logic [WIDTH-1:0]               dout_o,
   output logic                           valid_o,
   output logic                           empty_o,
   output logic                           full_o,
   output logic [$clog2(DEPTH+1)-1:0]     level_o,
   output logic                           overflow_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q, valid_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             ovf_q, ovf_d;
   logic             push_c, pop_c;

   // Next-state: a pop frees a slot, so a push into a full FIFO succeeds alongside it.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      pop_c    = pop_i && valid_q;
      push_c   = push_i && (!full_q || pop_c);
      ovf_d    = push_i && full_q && !pop_c;
      if (push_c) begin
         mem_d[wr_ptr_q] = din_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
      valid_d = (level_d != '0);
      empty_d = (level_d == '0);
      full_d  = (level_d == LVL_W'(DEPTH));
      head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
      end
   end

   assign dout_o     = head_q;
   assign valid_o    = valid_q;
   assign empty_o    = empty_q;
   assign full_o     = full_q;
   assign level_o    = level_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: tick divider, input synchronisers, clock glitch
// filter, 11-bit deframer with timeout, E0/F0 prefix folding, event FIFO.
//   CLK, RST_N          : board clock, async active-low reset
//   PS2_CLK, PS2_DATA   : asynchronous keyboard lines
//   KEY_VALID/KEY_READY : FIFO head handshake
//   KEY_CODE/EXT/BREAK  : head event
//   FRAME_ERR, OVERFLOW : one-cycle error pulses
//   FIFO_LEVEL          : stored event count
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_DIV       = 250,
   parameter int unsigned FILTER_LEN    = 4,
   parameter int unsigned TIMEOUT_TICKS = 4000,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                              CLK,
   input  logic                              RST_N,
   input  logic                              PS2_CLK,
   input  logic                              PS2_DATA,
   output logic                              KEY_VALID,
   input  logic                              KEY_READY,
   output logic [7:0]                        KEY_CODE,
   output logic                              KEY_EXT,
   output logic                              KEY_BREAK,
   output logic                              FRAME_ERR,
   output logic                              OVERFLOW,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_LEVEL
);

   localparam int unsigned DIV_W   = $clog2(CLK_DIV);
   localparam int unsigned TO_W    = $clog2(TIMEOUT_TICKS + 1);
   localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned ENTRY_W = $bits(ps2_entry_t);

   logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
   logic                      clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic                      dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic [FILTER_LEN-1:0]     filt_sr_q, filt_sr_d;
   logic                      filt_clk_q, filt_clk_d;
   ps2_state_e                state_q, state_d;
   logic [3:0]                bitcnt_q, bitcnt_d;
   logic [PS2_FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
   logic                      ext_q, ext_d, brk_q, brk_d;
   logic                      push_q, push_d;
   ps2_entry_t                entry_q, entry_d;
   logic                      err_q, err_d;
   logic                      frame_err_q, frame_err_d;

   logic                      tick_c, bit_evt_c;
   logic [7:0]                code_c;
   ps2_entry_t                fifo_head;
   logic                      fifo_empty, fifo_full;

   // Next-state for divider, synchronisers, filter, deframer and prefix flags.
   always_comb begin
      div_cnt_d   = div_cnt_q;
      clk_s1_d    = PS2_CLK;
      clk_s2_d    = clk_s1_q;
      dat_s1_d    = PS2_DATA;
      dat_s2_d    = dat_s1_q;
      filt_sr_d   = filt_sr_q;
      filt_clk_d  = filt_clk_q;
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      shreg_d     = shreg_q;
      to_cnt_d    = to_cnt_q;
      ext_d       = ext_q;
      brk_d       = brk_q;
      push_d      = 1'b0;
      entry_d     = entry_q;
      err_d       = 1'b0;
      frame_err_d = err_q;
      bit_evt_c   = 1'b0;
      code_c      = shreg_q[8:1];

      tick_c    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
      div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);

      // Filtered clock only moves once FILTER_LEN consecutive ticks agree.
      if (tick_c) begin
         filt_sr_d = (filt_sr_q << 1) | FILTER_LEN'(clk_s2_q);
         if (filt_sr_d == '0) begin
            filt_clk_d = 1'b0;
         end else if (&filt_sr_d) begin
            filt_clk_d = 1'b1;
         end
         bit_evt_c = filt_clk_q && !filt_clk_d;
      end

      case (state_q)
         IDLE: begin
            if (bit_evt_c && !dat_s2_q) begin
               state_d  = SHIFT;
               bitcnt_d = 4'd1;
               shreg_d  = {dat_s2_q, shreg_q[PS2_FRAME_BITS-1:1]};
               to_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (bit_evt_c) begin
               shreg_d  = {dat_s2_q, shreg_q[PS2_FRAME_BITS-1:1]};
               bitcnt_d = bitcnt_q + 4'd1;
               to_cnt_d = '0;
               if (bitcnt_q == 4'(PS2_FRAME_BITS - 1)) begin
                  state_d = CHECK;
               end
            end else if (tick_c) begin
               // Stalled frame: drop it silently along with any pending prefixes.
               if (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                  state_d  = IDLE;
                  bitcnt_d = '0;
                  to_cnt_d = '0;
                  ext_d    = 1'b0;
                  brk_d    = 1'b0;
               end else begin
                  to_cnt_d = to_cnt_q + TO_W'(1);
               end
            end
         end
         CHECK: begin
            state_d  = IDLE;
            bitcnt_d = '0;
            if (!ps2_frame_ok(shreg_q)) begin
               err_d = 1'b1;
               ext_d = 1'b0;
               brk_d = 1'b0;
            end else if (code_c == PS2_EXT_PREFIX) begin
               ext_d = 1'b1;
            end else if (code_c == PS2_BREAK_PREFIX) begin
               brk_d = 1'b1;
            end else begin
               push_d       = 1'b1;
               entry_d.ext  = ext_q;
               entry_d.brk  = brk_q;
               entry_d.code = code_c;
               ext_d        = 1'b0;
               brk_d        = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         div_cnt_q   <= '0;
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         filt_sr_q   <= '1;
         filt_clk_q  <= 1'b1;
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         shreg_q     <= '0;
         to_cnt_q    <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         push_q      <= 1'b0;
         entry_q     <= '0;
         err_q       <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         clk_s1_q    <= clk_s1_d;
         clk_s2_q    <= clk_s2_d;
         dat_s1_q    <= dat_s1_d;
         dat_s2_q    <= dat_s2_d;
         filt_sr_q   <= filt_sr_d;
         filt_clk_q  <= filt_clk_d;
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shreg_q     <= shreg_d;
         to_cnt_q    <= to_cnt_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         push_q      <= push_d;
         entry_q     <= entry_d;
         err_q       <= err_d;
         frame_err_q <= frame_err_d;
      end
   end

   ps2_rx_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (CLK),
      .rst_n      (RST_N),
      .push_i     (push_q),
      .din_i      (entry_q),
      .pop_i      (KEY_READY),
      .dout_o     (fifo_head),
      .valid_o    (KEY_VALID),
      .empty_o    (fifo_empty),
      .full_o     (fifo_full),
      .level_o    (FIFO_LEVEL),
      .overflow_o (OVERFLOW)
   );

   assign KEY_CODE  = fifo_head.code;
   assign KEY_EXT   = fifo_head.ext;
   assign KEY_BREAK = fifo_head.brk;
   assign FRAME_ERR = frame_err_q;

   // FIFO status flags must stay consistent with the level count.
   a_fifo_flags: assert property (@(posedge CLK) disable iff (!RST_N)
      !(fifo_full && fifo_empty) && (fifo_full == (FIFO_LEVEL == LVL_W'(FIFO_DEPTH))));

endmodule
